axi_w_arb: RTL and testbench

Two-manager AXI4 write-channel arbiter. It shares one write subordinate port (AW/W/B) between manager ports m0 and m1. Exactly one write transaction is in flight at a time; the grant is held from the AW handshake until the B handshake. It sits between a pair of write managers (for example a DMA engine and a test/debug requester) and a single `w_sub` endpoint.

---
 rtl/axi_w_arb.sv | 187 ++++++++++++++++++
 tb/tb_axi_w_arb.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_w_arb.sv
// axi_w_arb: two-manager AXI4 write-channel arbiter; one write transaction in flight, grant held AW→B.
// Optional macro AXI_W_ARB_BID_CHK_EN: B carries the AW-phase ID and a mismatched s_bid is reported as SLVERR.
module axi_w_arb #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int IW = 3,
   parameter int UW = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [AW-1:0]     m0_awaddr_i,
   input  logic [1:0]        m0_awburst_i,
   input  logic [2:0]        m0_awsize_i,
   input  logic [7:0]        m0_awlen_i,
   input  logic [UW-1:0]     m0_awuser_i,
   input  logic [IW-1:0]     m0_awid_i,
   input  logic              m0_awlock_i,
   input  logic              m0_awvalid_i,
   output logic              m0_awready_o,
   input  logic [DW-1:0]     m0_wdata_i,
   input  logic [DW/8-1:0]   m0_wstrb_i,
   input  logic              m0_wlast_i,
   input  logic              m0_wvalid_i,
   output logic              m0_wready_o,
   output logic [1:0]        m0_bresp_o,
   output logic [IW-1:0]     m0_bid_o,
   output logic              m0_bvalid_o,
   input  logic              m0_bready_i,
   input  logic [AW-1:0]     m1_awaddr_i,
   input  logic [1:0]        m1_awburst_i,
   input  logic [2:0]        m1_awsize_i,
   input  logic [7:0]        m1_awlen_i,
   input  logic [UW-1:0]     m1_awuser_i,
   input  logic [IW-1:0]     m1_awid_i,
   input  logic              m1_awlock_i,
   input  logic              m1_awvalid_i,
   output logic              m1_awready_o,
   input  logic [DW-1:0]     m1_wdata_i,
   input  logic [DW/8-1:0]   m1_wstrb_i,
   input  logic              m1_wlast_i,
   input  logic              m1_wvalid_i,
   output logic              m1_wready_o,
   output logic [1:0]        m1_bresp_o,
   output logic [IW-1:0]     m1_bid_o,
   output logic              m1_bvalid_o,
   input  logic              m1_bready_i,
   output logic [AW-1:0]     s_awaddr_o,
   output logic [1:0]        s_awburst_o,
   output logic [2:0]        s_awsize_o,
   output logic [7:0]        s_awlen_o,
   output logic [UW-1:0]     s_awuser_o,
   output logic [IW-1:0]     s_awid_o,
   output logic              s_awlock_o,
   output logic              s_awvalid_o,
   input  logic              s_awready_i,
   output logic [DW-1:0]     s_wdata_o,
   output logic [DW/8-1:0]   s_wstrb_o,
   output logic              s_wlast_o,
   output logic              s_wvalid_o,
   input  logic              s_wready_i,
   input  logic [1:0]        s_bresp_i,
   input  logic [IW-1:0]     s_bid_i,
   input  logic              s_bvalid_i,
   output logic              s_bready_o
);

   // state | meaning
   // IDLE  | nothing routed; pick a requester (prio breaks ties)
   // ADDR  | granted manager's AW routed to the subordinate
   // DATA  | granted manager's W routed; s_wlast from beat count
   // RESP  | subordinate B routed back to the granted manager
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t        state_q;
   logic          gnt_q;
   logic          prio_q;
   logic [7:0]    len_q;
   logic [7:0]    beat_cnt_q;

   logic          in_addr, in_data, in_resp;
   logic          sel_awvalid, sel_wvalid, sel_bready;
   logic [7:0]    sel_awlen;
   logic [IW-1:0] sel_awid;
   logic          aw_hs, w_hs, b_hs, w_last;
   logic [1:0]    b_resp;
   logic [IW-1:0] b_id;
   logic          unused_wlast;

   assign in_addr = (state_q == ADDR);
   assign in_data = (state_q == DATA);
   assign in_resp = (state_q == RESP);

   assign sel_awvalid = gnt_q ? m1_awvalid_i : m0_awvalid_i;
   assign sel_wvalid  = gnt_q ? m1_wvalid_i  : m0_wvalid_i;
   assign sel_bready  = gnt_q ? m1_bready_i  : m0_bready_i;
   assign sel_awlen   = gnt_q ? m1_awlen_i   : m0_awlen_i;
   assign sel_awid    = gnt_q ? m1_awid_i    : m0_awid_i;

   assign aw_hs  = in_addr && sel_awvalid && s_awready_i;
   assign w_hs   = in_data && sel_wvalid && s_wready_i;
   assign b_hs   = in_resp && s_bvalid_i && sel_bready;
   assign w_last = (beat_cnt_q == len_q);

   // Managers' own wlast is not trusted; the burst length captured on AW decides.
   assign unused_wlast = m0_wlast_i ^ m1_wlast_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         gnt_q      <= 1'b0;
         prio_q     <= 1'b0;
         len_q      <= '0;
         beat_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (m0_awvalid_i || m1_awvalid_i) begin
                  gnt_q   <= (m0_awvalid_i && m1_awvalid_i) ? prio_q : m1_awvalid_i;
                  state_q <= ADDR;
               end
            end
            ADDR: begin
               if (aw_hs) begin
                  len_q      <= sel_awlen;
                  beat_cnt_q <= '0;
                  state_q    <= DATA;
               end
            end
            DATA: begin
               if (w_hs) begin
                  beat_cnt_q <= beat_cnt_q + 8'd1;
                  if (w_last) state_q <= RESP;
               end
            end
            RESP: begin
               if (b_hs) begin
                  prio_q  <= ~gnt_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef AXI_W_ARB_BID_CHK_EN
   logic [IW-1:0] id_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)      id_q <= '0;
      else if (aw_hs) id_q <= sel_awid;
   end

   assign b_id   = id_q;
   assign b_resp = (s_bid_i != id_q) ? 2'b10 : s_bresp_i;
`else
   assign b_id   = s_bid_i;
   assign b_resp = s_bresp_i;
`endif

   assign s_awaddr_o  = in_addr ? (gnt_q ? m1_awaddr_i  : m0_awaddr_i)  : '0;
   assign s_awburst_o = in_addr ? (gnt_q ? m1_awburst_i : m0_awburst_i) : '0;
   assign s_awsize_o  = in_addr ? (gnt_q ? m1_awsize_i  : m0_awsize_i)  : '0;
   assign s_awlen_o   = in_addr ? sel_awlen : '0;
   assign s_awuser_o  = in_addr ? (gnt_q ? m1_awuser_i  : m0_awuser_i)  : '0;
   assign s_awid_o    = in_addr ? sel_awid : '0;
   assign s_awlock_o  = in_addr && (gnt_q ? m1_awlock_i : m0_awlock_i);
   assign s_awvalid_o = in_addr && sel_awvalid;
   assign m0_awready_o = in_addr && !gnt_q && s_awready_i;
   assign m1_awready_o = in_addr &&  gnt_q && s_awready_i;

   assign s_wdata_o   = in_data ? (gnt_q ? m1_wdata_i : m0_wdata_i) : '0;
   assign s_wstrb_o   = in_data ? (gnt_q ? m1_wstrb_i : m0_wstrb_i) : '0;
   assign s_wlast_o   = in_data && w_last;
   assign s_wvalid_o  = in_data && sel_wvalid;
   assign m0_wready_o = in_data && !gnt_q && s_wready_i;
   assign m1_wready_o = in_data &&  gnt_q && s_wready_i;

   assign m0_bvalid_o = in_resp && !gnt_q && s_bvalid_i;
   assign m1_bvalid_o = in_resp &&  gnt_q && s_bvalid_i;
   assign m0_bresp_o  = (in_resp && !gnt_q) ? b_resp : '0;
   assign m1_bresp_o  = (in_resp &&  gnt_q) ? b_resp : '0;
   assign m0_bid_o    = (in_resp && !gnt_q) ? b_id : '0;
   assign m1_bid_o    = (in_resp &&  gnt_q) ? b_id : '0;
   assign s_bready_o  = in_resp && sel_bready;

endmodule

// File: tb/tb_axi_w_arb.sv
// tb_axi_w_arb: randomized transactions against a transaction-level model of the arbiter
// (grant preference, burst beats, B routing and optional ID check).
module tb_axi_w_arb;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int IW = 3;
   localparam int UW = 32;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [AW-1:0] m_awaddr [2];
   logic [1:0]    m_awburst[2];
   logic [2:0]    m_awsize [2];
   logic [7:0]    m_awlen  [2];
   logic [UW-1:0] m_awuser [2];
   logic [IW-1:0] m_awid   [2];
   logic          m_awlock [2];
   logic          m_awvalid[2];
   logic          m_awready[2];
   logic [DW-1:0] m_wdata  [2];
   logic [SW-1:0] m_wstrb  [2];
   logic          m_wlast  [2];
   logic          m_wvalid [2];
   logic          m_wready [2];
   logic [1:0]    m_bresp  [2];
   logic [IW-1:0] m_bid    [2];
   logic          m_bvalid [2];
   logic          m_bready [2];

   logic [AW-1:0] s_awaddr;
   logic [1:0]    s_awburst;
   logic [2:0]    s_awsize;
   logic [7:0]    s_awlen;
   logic [UW-1:0] s_awuser;
   logic [IW-1:0] s_awid;
   logic          s_awlock, s_awvalid, s_awready;
   logic [DW-1:0] s_wdata;
   logic [SW-1:0] s_wstrb;
   logic          s_wlast, s_wvalid, s_wready;
   logic [1:0]    s_bresp;
   logic [IW-1:0] s_bid;
   logic          s_bvalid, s_bready;

   logic any_out;
   assign any_out = |{m_awready[0], m_awready[1], m_wready[0], m_wready[1],
                      m_bresp[0], m_bresp[1], m_bid[0], m_bid[1], m_bvalid[0], m_bvalid[1],
                      s_awaddr, s_awburst, s_awsize, s_awlen, s_awuser, s_awid, s_awlock, s_awvalid,
                      s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready};

   axi_w_arb #(.AW(AW), .DW(DW), .IW(IW), .UW(UW)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_awaddr_i(m_awaddr[0]), .m0_awburst_i(m_awburst[0]), .m0_awsize_i(m_awsize[0]),
      .m0_awlen_i(m_awlen[0]), .m0_awuser_i(m_awuser[0]), .m0_awid_i(m_awid[0]),
      .m0_awlock_i(m_awlock[0]), .m0_awvalid_i(m_awvalid[0]), .m0_awready_o(m_awready[0]),
      .m0_wdata_i(m_wdata[0]), .m0_wstrb_i(m_wstrb[0]), .m0_wlast_i(m_wlast[0]),
      .m0_wvalid_i(m_wvalid[0]), .m0_wready_o(m_wready[0]),
      .m0_bresp_o(m_bresp[0]), .m0_bid_o(m_bid[0]), .m0_bvalid_o(m_bvalid[0]), .m0_bready_i(m_bready[0]),
      .m1_awaddr_i(m_awaddr[1]), .m1_awburst_i(m_awburst[1]), .m1_awsize_i(m_awsize[1]),
      .m1_awlen_i(m_awlen[1]), .m1_awuser_i(m_awuser[1]), .m1_awid_i(m_awid[1]),
      .m1_awlock_i(m_awlock[1]), .m1_awvalid_i(m_awvalid[1]), .m1_awready_o(m_awready[1]),
      .m1_wdata_i(m_wdata[1]), .m1_wstrb_i(m_wstrb[1]), .m1_wlast_i(m_wlast[1]),
      .m1_wvalid_i(m_wvalid[1]), .m1_wready_o(m_wready[1]),
      .m1_bresp_o(m_bresp[1]), .m1_bid_o(m_bid[1]), .m1_bvalid_o(m_bvalid[1]), .m1_bready_i(m_bready[1]),
      .s_awaddr_o(s_awaddr), .s_awburst_o(s_awburst), .s_awsize_o(s_awsize), .s_awlen_o(s_awlen),
      .s_awuser_o(s_awuser), .s_awid_o(s_awid), .s_awlock_o(s_awlock), .s_awvalid_o(s_awvalid),
      .s_awready_i(s_awready),
      .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_wlast_o(s_wlast), .s_wvalid_o(s_wvalid),
      .s_wready_i(s_wready),
      .s_bresp_i(s_bresp), .s_bid_i(s_bid), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready)
   );

   int n_checks, n_fail;
   int pref;                         // model: manager preferred on a tie
   int cfg_awid, cfg_bid, cfg_bresp; // -1 = randomize

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int m = 0; m < 2; m++) begin
         m_awaddr[m] = '0; m_awburst[m] = '0; m_awsize[m] = '0; m_awlen[m] = '0;
         m_awuser[m] = '0; m_awid[m] = '0; m_awlock[m] = 1'b0; m_awvalid[m] = 1'b0;
         m_wdata[m] = '0; m_wstrb[m] = '0; m_wlast[m] = 1'b0; m_wvalid[m] = 1'b0;
         m_bready[m] = 1'b0;
      end
      s_awready = 1'b0; s_wready = 1'b0;
      s_bresp = '0; s_bid = '0; s_bvalid = 1'b0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      pref = 0;
   endtask

   task automatic randomize_aw(input int m, input int len);
      m_awaddr[m]  = {m[0], 31'($urandom)};
      m_awburst[m] = 2'($urandom);
      m_awsize[m]  = 3'($urandom);
      m_awlen[m]   = 8'(len);
      m_awuser[m]  = UW'($urandom);
      m_awid[m]    = (cfg_awid >= 0) ? IW'(cfg_awid) : IW'($urandom);
      m_awlock[m]  = 1'($urandom);
   endtask

   // One full transaction; abort_at >= 0 asserts rst after that many W handshakes.
   task automatic do_txn(input int mask, input int len, input int wmode, input int pre_w, input int abort_at);
      int g, o, beats, hs, cyc;
      bit r0, r1, wr;
      logic [DW-1:0] data[$];
      logic [1:0] rresp, exp_resp;
      logic [IW-1:0] rbid, exp_bid;

      for (int m = 0; m < 2; m++)
         if (mask[m] && !m_awvalid[m]) randomize_aw(m, len);
      r0 = m_awvalid[0] || mask[0];
      r1 = m_awvalid[1] || mask[1];
      g = (r0 && r1) ? pref : (r1 ? 1 : 0);
      o = 1 - g;
      beats = int'(m_awlen[g]) + 1;
      for (int b = 0; b < beats; b++) data.push_back(DW'($urandom));
      m_wdata[g] = data[0];
      m_wstrb[g] = SW'($urandom);
      s_wready = 1'b1;

      if (pre_w != 0) begin
         m_wvalid[g] = 1'b1;
         for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (m_wready[g] !== 1'b0) begin n_fail++; $display("FAIL early_w_held: wready=%b exp 0", m_wready[g]); end
         end
      end

      if (mask[0]) m_awvalid[0] = 1'b1;
      if (mask[1]) m_awvalid[1] = 1'b1;
      s_awready = 1'b0;
      #1;
      n_checks++; if (s_awvalid !== 1'b0) begin n_fail++; $display("FAIL aw_idle: s_awvalid=%b exp 0", s_awvalid); end
      step();
      n_checks++; if (s_awvalid !== 1'b1) begin n_fail++; $display("FAIL aw_latency: s_awvalid=%b exp 1", s_awvalid); end
      n_checks++; if (s_awaddr !== m_awaddr[g]) begin n_fail++; $display("FAIL aw_grant_addr: got %h exp %h (mgr %0d)", s_awaddr, m_awaddr[g], g); end
      n_checks++; if ({s_awlen, s_awid, s_awuser, s_awburst, s_awsize, s_awlock} !== {m_awlen[g], m_awid[g], m_awuser[g], m_awburst[g], m_awsize[g], m_awlock[g]}) begin
         n_fail++; $display("FAIL aw_fields: len=%h id=%h exp len=%h id=%h", s_awlen, s_awid, m_awlen[g], m_awid[g]); end
      n_checks++; if (m_wready[g] !== 1'b0) begin n_fail++; $display("FAIL w_before_aw: wready=%b exp 0", m_wready[g]); end
      s_awready = 1'b1;
      #1;
      n_checks++; if (m_awready[g] !== 1'b1 || m_awready[o] !== 1'b0) begin
         n_fail++; $display("FAIL awready_route: g=%b o=%b exp 1/0", m_awready[g], m_awready[o]); end
      step();
      m_awvalid[g] = 1'b0;
      s_awready = 1'b0;

      hs = 0; cyc = 0;
      m_wvalid[g] = 1'b1;
      while (hs < beats && cyc < 4000) begin
         if (abort_at >= 0 && hs == abort_at) break;
         case (wmode)
            0: wr = ($urandom_range(3) != 0);
            1: wr = cyc[0];
            default: wr = 1'b1;
         endcase
         s_wready = wr;
         m_wlast[g] = 1'($urandom);
         m_wvalid[o] = 1'($urandom);
         m_wdata[o] = DW'($urandom);
         #1;
         n_checks++; if (s_wvalid !== 1'b1 || s_wdata !== data[hs] || s_wstrb !== m_wstrb[g]) begin
            n_fail++; $display("FAIL w_beat%0d: valid=%b data=%h exp 1 %h", hs, s_wvalid, s_wdata, data[hs]); end
         n_checks++; if (s_wlast !== (hs == beats - 1)) begin
            n_fail++; $display("FAIL w_last beat%0d: got %b exp %b", hs, s_wlast, (hs == beats - 1)); end
         n_checks++; if (m_wready[g] !== wr || m_wready[o] !== 1'b0) begin
            n_fail++; $display("FAIL wready_route: g=%b o=%b exp %b/0", m_wready[g], m_wready[o], wr); end
         step();
         if (wr) begin
            hs++;
            if (hs < beats) m_wdata[g] = data[hs];
         end
         cyc++;
      end
      m_wvalid[o] = 1'b0;

      if (abort_at >= 0) begin
         rst = 1'b1;
         s_bvalid = 1'b1; s_bresp = 2'($urandom); s_bid = IW'($urandom);
         m_bready[0] = 1'b1; m_bready[1] = 1'b1;
         #1;
         n_checks++; if (any_out !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: any_out=%b exp 0", any_out); end
         step();
         rst = 1'b0;
         pref = 0;
         step();
         n_checks++; if (m_bvalid[0] !== 1'b0 || m_bvalid[1] !== 1'b0 || s_bready !== 1'b0 || s_wvalid !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_b: bvalid=%b%b s_bready=%b exp 0", m_bvalid[1], m_bvalid[0], s_bready); end
         clear_inputs();
         return;
      end

      n_checks++; if (hs != beats) begin n_fail++; $display("FAIL w_timeout: beats=%0d exp %0d", hs, beats); end
      s_wready = 1'b1;
      #1;
      n_checks++; if (s_wvalid !== 1'b0 || m_wready[g] !== 1'b0) begin
         n_fail++; $display("FAIL w_extra_beat: s_wvalid=%b wready=%b exp 0", s_wvalid, m_wready[g]); end
      m_wvalid[g] = 1'b0;
      s_wready = 1'b0;

      rresp = (cfg_bresp >= 0) ? 2'(cfg_bresp) : 2'($urandom);
      rbid  = (cfg_bid >= 0) ? IW'(cfg_bid) : (($urandom_range(1) == 1) ? m_awid[g] : IW'($urandom));
`ifdef AXI_W_ARB_BID_CHK_EN
      exp_bid  = m_awid[g];
      exp_resp = (rbid != m_awid[g]) ? 2'b10 : rresp;
`else
      exp_bid  = rbid;
      exp_resp = rresp;
`endif
      s_bvalid = 1'b1; s_bresp = rresp; s_bid = rbid;
      m_bready[g] = 1'b0;
      #1;
      n_checks++; if (m_bvalid[g] !== 1'b1 || m_bvalid[o] !== 1'b0 || s_bready !== 1'b0) begin
         n_fail++; $display("FAIL b_route: g=%b o=%b s_bready=%b exp 1/0/0", m_bvalid[g], m_bvalid[o], s_bready); end
      n_checks++; if (m_bresp[g] !== exp_resp || m_bid[g] !== exp_bid) begin
         n_fail++; $display("FAIL b_fields: resp=%h id=%h exp %h %h", m_bresp[g], m_bid[g], exp_resp, exp_bid); end
      n_checks++; if (m_bresp[o] !== 2'b00 || m_bid[o] !== '0) begin
         n_fail++; $display("FAIL b_other_zero: resp=%h id=%h exp 0", m_bresp[o], m_bid[o]); end
      step();
      m_bready[g] = 1'b1;
      #1;
      n_checks++; if (s_bready !== 1'b1 || m_bvalid[g] !== 1'b1) begin
         n_fail++; $display("FAIL b_hold: s_bready=%b bvalid=%b exp 1/1", s_bready, m_bvalid[g]); end
      step();
      s_bvalid = 1'b0;
      m_bready[g] = 1'b0;
      pref = o;
      n_checks++; if (s_awvalid !== 1'b0 || m_bvalid[g] !== 1'b0) begin
         n_fail++; $display("FAIL turnaround: s_awvalid=%b bvalid=%b exp 0", s_awvalid, m_bvalid[g]); end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      for (int m = 0; m < 2; m++) begin
         randomize_aw(m, 0);
         m_awvalid[m] = 1'b1; m_wvalid[m] = 1'b1; m_bready[m] = 1'b1;
         m_wdata[m] = DW'($urandom);
      end
      s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b11; s_bid = '1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (any_out !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: any_out=%b exp 0", any_out); end
      end
      rst = 1'b0;
      pref = 0;
      step();
      n_checks++; if (s_awvalid !== 1'b1 || s_awaddr !== m_awaddr[0]) begin
         n_fail++; $display("FAIL reset_first_grant: valid=%b addr=%h exp 1 %h", s_awvalid, s_awaddr, m_awaddr[0]); end
      n_checks++; if (m_awready[0] !== 1'b1 || m_awready[1] !== 1'b0) begin
         n_fail++; $display("FAIL reset_awready: %b%b exp 01", m_awready[1], m_awready[0]); end
      reset_dut();
   endtask

   task automatic test_fairness();
      reset_dut();
      repeat (4) do_txn(3, 0, 2, 0, -1);
      reset_dut();
   endtask

   task automatic test_burst_toggle();
      reset_dut();
      do_txn(2, 3, 1, 0, -1);
   endtask

   task automatic test_early_w();
      reset_dut();
      do_txn(1, 1, 2, 1, -1);
   endtask

   task automatic test_bid();
      reset_dut();
      cfg_awid = 5; cfg_bid = 2; cfg_bresp = 0;
      do_txn(1, 0, 2, 0, -1);
      cfg_awid = -1; cfg_bid = -1; cfg_bresp = -1;
   endtask

   task automatic test_reset_mid_burst();
      reset_dut();
      do_txn(1, 0, 2, 0, -1);
      do_txn(2, 3, 2, 0, 2);
      do_txn(3, 0, 2, 0, -1);
      reset_dut();
   endtask

   task automatic test_random();
      reset_dut();
      repeat (12) do_txn(int'($urandom_range(3, 1)), int'($urandom_range(7, 0)), 0, 0, -1);
      reset_dut();
   endtask

   task automatic test_len_max();
      reset_dut();
      do_txn(2, 255, 0, 0, -1);
   endtask

   initial begin
      n_checks = 0; n_fail = 0; pref = 0;
      cfg_awid = -1; cfg_bid = -1; cfg_bresp = -1;
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_fairness();
      test_burst_toggle();
      test_early_w();
      test_bid();
      test_reset_mid_burst();
      test_random();
      test_len_max();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
